// File: rtl/current_loop_pi_pkg.sv
// Shared motor-control definitions: FSM encoding, midscale helper and default loop widths.
package MotorControlPkg;

    localparam int DEF_GAIN_FRAC = 12;
    localparam int DEF_ACC_WIDTH = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ERR   = 3'd1,
        ST_MUL_P = 3'd2,
        ST_MUL_I = 3'd3,
        ST_SUM   = 3'd4,
        ST_SAT   = 3'd5,
        ST_OUT   = 3'd6
    } state_t;

    function automatic int midscale(input int counter_width);
        return 1 << counter_width;
    endfunction

endpackage

// File: rtl/current_loop_pi_sat_clamp.sv
// Signed-input clamp to [lo, hi]; the result is the low OUT_W bits of the clamped value.
module sat_clamp #(
    parameter int IN_W  = 36,
    parameter int OUT_W = 11
) (
    input  logic signed [IN_W-1:0]  x,
    input  logic signed [IN_W-1:0]  lo,
    input  logic signed [IN_W-1:0]  hi,
    output logic        [OUT_W-1:0] y,
    output logic                    lo_flag,
    output logic                    hi_flag
);

    always_comb begin
        hi_flag = 1'b0;
        lo_flag = 1'b0;
        y       = x[OUT_W-1:0];
        if (x > hi) begin
            hi_flag = 1'b1;
            y       = hi[OUT_W-1:0];
        end else if (x < lo) begin
            lo_flag = 1'b1;
            y       = lo[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/current_loop_pi.sv
// Current-loop PI controller with one time-shared multiplier and a fixed 6-clock update latency.
// Optional feed-forward input ff_term is enabled by defining CURRENT_LOOP_FF_EN.
module current_loop_pi
    import MotorControlPkg::*;
#(
    parameter int COUNTER_WIDTH = 10,
    parameter int DATA_WIDTH    = 16,
    parameter int GAIN_FRAC     = DEF_GAIN_FRAC,
    parameter int ACC_WIDTH     = DEF_ACC_WIDTH
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         feedback_calculation_start,
    input  logic                         adc_data_ready,
    input  logic signed [DATA_WIDTH-1:0] adc_sample,
    input  logic signed [DATA_WIDTH-1:0] setpoint,
    input  logic        [DATA_WIDTH-1:0] kp,
    input  logic        [DATA_WIDTH-1:0] ki,
    input  logic        [ACC_WIDTH-2:0]  i_limit,
    input  logic [COUNTER_WIDTH:0]       duty_min,
    input  logic [COUNTER_WIDTH:0]       duty_max,
    input  logic                         loop_enable,
`ifdef CURRENT_LOOP_FF_EN
    input  logic signed [DATA_WIDTH-1:0] ff_term,
`endif
    output logic [COUNTER_WIDTH:0]       duty,
    output logic                         duty_valid,
    output logic                         busy,
    output logic                         sat_flag,
    output logic                         overrun,
    output logic                         stale,
    output logic [2:0]                   dbg_state
);

    localparam int E_W   = DATA_WIDTH + 1;
    localparam int P_W   = 2 * DATA_WIDTH + 1;
    localparam int A1_W  = ACC_WIDTH + 1;
    localparam int SUM_W = ((P_W > ACC_WIDTH) ? P_W : ACC_WIDTH) + 3;
    localparam int D_W   = COUNTER_WIDTH + 1;
    localparam logic [D_W-1:0]          MID_D = D_W'(midscale(COUNTER_WIDTH));
    localparam logic signed [SUM_W-1:0] MID_S = SUM_W'(midscale(COUNTER_WIDTH));

    state_t                         state;
    logic signed [DATA_WIDTH-1:0]   sp_q, smp_q;
    logic signed [E_W-1:0]          e_q;
    logic signed [P_W-1:0]          p_q;
    logic signed [ACC_WIDTH-1:0]    acc;
    logic signed [SUM_W-1:0]        u_q;
    logic        [D_W-1:0]          duty_nx;
    logic                           sat_dir;

    assign dbg_state = state;

    // Single multiplier: kp during MUL_P, ki during MUL_I.
    logic        [DATA_WIDTH-1:0] mul_gain;
    logic signed [P_W-1:0]        gain_x, e_x, prod;
    assign mul_gain = (state == ST_MUL_I) ? ki : kp;
    assign gain_x   = {{(P_W-DATA_WIDTH){1'b0}}, mul_gain};
    assign e_x      = {{(P_W-E_W){e_q[E_W-1]}}, e_q};
    assign prod     = gain_x * e_x;

    logic signed [A1_W-1:0]      di_x, acc_sum, int_hi_lim, int_lo_lim;
    logic        [ACC_WIDTH-1:0] acc_clamped;
    logic                        int_lo, int_hi;
    assign di_x       = A1_W'(prod);
    assign acc_sum    = A1_W'(acc) + di_x;
    assign int_hi_lim = {2'b00, i_limit};
    assign int_lo_lim = -int_hi_lim;

    sat_clamp #(.IN_W(A1_W), .OUT_W(ACC_WIDTH)) u_int_clamp (
        .x(acc_sum), .lo(int_lo_lim), .hi(int_hi_lim),
        .y(acc_clamped), .lo_flag(int_lo), .hi_flag(int_hi)
    );

    // The integrator only needs the clamped value, not which bound was hit.
    logic unused_int_flags;
    assign unused_int_flags = int_lo | int_hi;

    // Hold the integrator when the last output was pinned and the error pushes further into the rail.
    logic e_neg, e_pos, hold_int;
    assign e_neg    = e_q[E_W-1];
    assign e_pos    = !e_neg && (|e_q);
    assign hold_int = sat_flag && ((sat_dir && e_pos) || (!sat_dir && e_neg));

    logic signed [SUM_W-1:0] ff_x, sum_pa, u_next;
`ifdef CURRENT_LOOP_FF_EN
    assign ff_x = SUM_W'(ff_term);
`else
    assign ff_x = '0;
`endif
    assign sum_pa = SUM_W'(p_q) + SUM_W'(acc);
    assign u_next = (sum_pa >>> GAIN_FRAC) + ff_x + MID_S;

    logic signed [SUM_W-1:0] duty_lo_x, duty_hi_x;
    logic        [D_W-1:0]   duty_c;
    logic                    duty_lo, duty_hi;
    assign duty_lo_x = {{(SUM_W-D_W){1'b0}}, duty_min};
    assign duty_hi_x = {{(SUM_W-D_W){1'b0}}, duty_max};

    sat_clamp #(.IN_W(SUM_W), .OUT_W(D_W)) u_duty_clamp (
        .x(u_q), .lo(duty_lo_x), .hi(duty_hi_x),
        .y(duty_c), .lo_flag(duty_lo), .hi_flag(duty_hi)
    );

    always_ff @(posedge clk) begin
        if (!rstn || !loop_enable) begin
            state      <= ST_IDLE;
            sp_q       <= '0;
            smp_q      <= '0;
            e_q        <= '0;
            p_q        <= '0;
            acc        <= '0;
            u_q        <= '0;
            duty_nx    <= MID_D;
            duty       <= MID_D;
            duty_valid <= 1'b0;
            busy       <= 1'b0;
            sat_flag   <= 1'b0;
            sat_dir    <= 1'b0;
            overrun    <= 1'b0;
            stale      <= 1'b0;
        end else begin
            duty_valid <= 1'b0;
            if (feedback_calculation_start && state != ST_IDLE)
                overrun <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (feedback_calculation_start) begin
                        if (adc_data_ready) begin
                            sp_q  <= setpoint;
                            smp_q <= adc_sample;
                            busy  <= 1'b1;
                            state <= ST_ERR;
                        end else begin
                            stale <= 1'b1;
                        end
                    end
                end
                ST_ERR: begin
                    e_q   <= E_W'(sp_q) - E_W'(smp_q);
                    state <= ST_MUL_P;
                end
                ST_MUL_P: begin
                    p_q   <= prod;
                    state <= ST_MUL_I;
                end
                ST_MUL_I: begin
                    if (!hold_int)
                        acc <= acc_clamped;
                    state <= ST_SUM;
                end
                ST_SUM: begin
                    u_q   <= u_next;
                    state <= ST_SAT;
                end
                ST_SAT: begin
                    duty_nx  <= duty_c;
                    sat_flag <= duty_lo | duty_hi;
                    sat_dir  <= duty_hi;
                    state    <= ST_OUT;
                end
                ST_OUT: begin
                    duty       <= duty_nx;
                    duty_valid <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_current_loop_pi.sv
// Directed bench for current_loop_pi: a reference PI model predicts each duty word into a queue,
// and a negedge monitor pops and compares duty, sat_flag and arrival cycle on every duty_valid.
module tb_current_loop_pi;

  localparam int DW = 11;

  logic               clk = 1'b0;
  logic               rstn;
  logic               feedback_calculation_start;
  logic               adc_data_ready;
  logic signed [15:0] adc_sample;
  logic signed [15:0] setpoint;
  logic [15:0]        kp;
  logic [15:0]        ki;
  logic [30:0]        i_limit;
  logic [DW-1:0]      duty_min;
  logic [DW-1:0]      duty_max;
  logic               loop_enable;
`ifdef CURRENT_LOOP_FF_EN
  logic signed [15:0] ff_term;
`endif
  logic [DW-1:0]      duty;
  logic               duty_valid;
  logic               busy;
  logic               sat_flag;
  logic               overrun;
  logic               stale;
  logic [2:0]         dbg_state;

  current_loop_pi dut (
    .clk(clk),
    .rstn(rstn),
    .feedback_calculation_start(feedback_calculation_start),
    .adc_data_ready(adc_data_ready),
    .adc_sample(adc_sample),
    .setpoint(setpoint),
    .kp(kp),
    .ki(ki),
    .i_limit(i_limit),
    .duty_min(duty_min),
    .duty_max(duty_max),
    .loop_enable(loop_enable),
`ifdef CURRENT_LOOP_FF_EN
    .ff_term(ff_term),
`endif
    .duty(duty),
    .duty_valid(duty_valid),
    .busy(busy),
    .sat_flag(sat_flag),
    .overrun(overrun),
    .stale(stale),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int neg_cnt = 0;
  int spurious = 0;

  // scoreboard queues
  logic [DW-1:0] exp_q[$];
  logic          sat_q[$];
  int            t_q[$];

  // reference model state
  longint   m_acc = 0;
  bit       m_sat = 0;
  bit       m_dir = 0;
  logic [DW-1:0] m_duty = 11'd1024;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_sat = 0;
    m_dir = 0;
    m_duty = 11'd1024;
  endtask

  task automatic predict(output logic [DW-1:0] d, output logic s);
    longint e, p, di, a, lim, u, ff;
    e = longint'(setpoint) - longint'(adc_sample);
    p = longint'(kp) * e;
    di = longint'(ki) * e;
    ff = 0;
`ifdef CURRENT_LOOP_FF_EN
    ff = longint'(ff_term);
`endif
    if (!(m_sat && ((m_dir && e > 0) || (!m_dir && e < 0)))) begin
      a = m_acc + di;
      lim = longint'(i_limit);
      if (a > lim) a = lim;
      else if (a < -lim) a = -lim;
      m_acc = a;
    end
    u = ((p + m_acc) >>> 12) + ff + 1024;
    if (u > longint'(duty_max)) begin
      d = duty_max; s = 1'b1; m_dir = 1'b1;
    end else if (u < longint'(duty_min)) begin
      d = duty_min; s = 1'b1; m_dir = 1'b0;
    end else begin
      d = u[DW-1:0]; s = 1'b0;
    end
    m_sat = s;
    m_duty = d;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // driver: one start pulse; accepted starts get a predicted result in the scoreboard
  task automatic do_start(input bit accepted);
    logic [DW-1:0] d;
    logic s;
    feedback_calculation_start = 1'b1;
    if (accepted) begin
      predict(d, s);
      exp_q.push_back(d);
      sat_q.push_back(s);
      t_q.push_back(neg_cnt + 8);
    end
    tick(1);
    feedback_calculation_start = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) tick(1);
    check("drain", exp_q.size(), 0);
  endtask

  // monitor
  always @(negedge clk) begin
    neg_cnt++;
    if (duty_valid) begin
      if (exp_q.size() == 0) begin
        spurious++;
      end else begin
        check("duty", duty, exp_q.pop_front());
        check("sat_flag", sat_flag, sat_q.pop_front());
        check("latency", neg_cnt, t_q.pop_front());
      end
    end
  end

  initial begin
    rstn = 1'b0;
    feedback_calculation_start = 1'b0;
    adc_data_ready = 1'b1;
    adc_sample = 16'sd0;
    setpoint = 16'sd0;
    kp = 16'h1000;
    ki = 16'h0000;
    i_limit = 31'd1 << 30;
    duty_min = 11'd0;
    duty_max = 11'd2047;
    loop_enable = 1'b1;
`ifdef CURRENT_LOOP_FF_EN
    ff_term = 16'sd0;
`endif
    tick(3);
    check("rst_duty", duty, 1024);
    check("rst_state", dbg_state, 0);
    check("rst_busy", busy, 0);
    rstn = 1'b1;
    tick(100);
    check("idle_duty", duty, 1024);
    check("idle_flags", {duty_valid, busy, sat_flag, overrun, stale}, 0);

    // proportional only: e=100 at kp=1.0
    setpoint = 16'sd100;
    do_start(1'b1);
    check("busy_run", busy, 1);
    wait_drain();
    check("busy_done", busy, 0);
    check("valid_one_cycle", duty_valid, 0);

    // integral ramp into the upper clamp; anti-windup holds the integrator
    kp = 16'h0000;
    ki = 16'h1000;
    setpoint = 16'sd500;
    do_start(1'b1); wait_drain(); tick(2048);
    duty_max = 11'd1500;
    do_start(1'b1); wait_drain(); tick(2048);
    do_start(1'b1); wait_drain(); tick(2048);
    duty_max = 11'd2047;
    do_start(1'b1); wait_drain(); tick(20);
    check("ramp_hold_duty", duty, 2024);

    // stale sample
    adc_data_ready = 1'b0;
    do_start(1'b0);
    tick(10);
    check("stale_flag", stale, 1);
    check("stale_duty", duty, m_duty);
    adc_data_ready = 1'b1;

    // overrun: second start 3 clocks after the first
    ki = 16'h0000;
    duty_max = 11'd1500;
    do_start(1'b1);
    tick(2);
    do_start(1'b0);
    wait_drain();
    tick(10);
    check("overrun_flag", overrun, 1);
    check("stale_sticky", stale, 1);
    check("overrun_sat", sat_flag, 1);

    // loop_enable dropped at clock 3 of an update
    duty_max = 11'd2047;
    do_start(1'b0);
    tick(2);
    loop_enable = 1'b0;
    tick(1);
    check("dis_duty", duty, 1024);
    check("dis_flags", {busy, sat_flag, overrun, stale}, 0);
    check("dis_state", dbg_state, 0);
    loop_enable = 1'b1;
    model_reset();
    tick(10);
    setpoint = 16'sd100;
    do_start(1'b1); wait_drain(); tick(10);
    check("acc_cleared", duty, 1024);

`ifdef CURRENT_LOOP_FF_EN
    kp = 16'h1000;
    setpoint = 16'sd0;
    adc_sample = 16'sd0;
    ff_term = -16'sd24;
    do_start(1'b1); wait_drain(); tick(10);
    check("ff_duty", duty, 1000);
    ff_term = 16'sd0;
`endif

    // negative error and floor behaviour of the arithmetic shift
    kp = 16'h1000; ki = 16'h0000;
    setpoint = 16'sd0; adc_sample = 16'sd100;
    do_start(1'b1); wait_drain(); tick(10);
    kp = 16'h0800; adc_sample = 16'sd3;
    do_start(1'b1); wait_drain(); tick(10);

    // lower clamp then anti-windup in the low direction
    kp = 16'h1000; adc_sample = 16'sd500; duty_min = 11'd1000;
    do_start(1'b1); wait_drain(); tick(10);
    kp = 16'h0000; ki = 16'h1000;
    do_start(1'b1); wait_drain(); tick(10);
    do_start(1'b1); wait_drain(); tick(10);
    duty_min = 11'd0;

    // random data updates
    for (int i = 0; i < 6; i++) begin
      kp = 16'($urandom_range(0, 16'h2000));
      ki = 16'($urandom_range(0, 16'h0400));
      setpoint = 16'($urandom_range(0, 2000)) - 16'sd1000;
      adc_sample = 16'($urandom_range(0, 2000)) - 16'sd1000;
      do_start(1'b1); wait_drain(); tick(10);
    end

    // reset mid-update
    do_start(1'b0);
    tick(2);
    rstn = 1'b0;
    tick(1);
    check("midrst_duty", duty, 1024);
    check("midrst_state", dbg_state, 0);
    rstn = 1'b1;
    model_reset();
    tick(20);

    check("spurious_valids", spurious, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
